seq_pattern_tx: RTL and testbench

//  Serial pattern transmitter: the driving end of the 111/101 overlapping-detector link.
//  - Accepts a parallel word over a valid/ready handshake and shifts it out MSB-first on 'o'.
//  - Drives 'o'=0 for a fixed gap after each frame so a downstream detector returns to its idle state.
//  - Reports how many overlapping 111/101 hits the detector must see in the frame.
//  - Used as stimulus source and scoreboard reference for the detector.

---
 rtl/seq_pkg.sv | 21 ++
 rtl/seq_hit_model.sv | 36 +++
 rtl/seq_pattern_tx.sv | 141 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the 111/101 pattern transmitter.
//   tx_state_t : transmitter FSM states
//   GAP_MIN    : smallest idle-zero gap that returns the detector to idle
//   eff_gap()  : raises a too-small gap parameter to GAP_MIN
package seq_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_SHIFT = 2'd1,
    TX_GAP   = 2'd2
  } tx_state_t;

  localparam int GAP_MIN = 2;

  // Two zeros drive the detector back to idle from any state, so a
  // shorter gap would let one frame's tail bits leak into the next frame.
  function automatic int eff_gap(input int g);
    return (g < GAP_MIN) ? GAP_MIN : g;
  endfunction

endpackage

// File: rtl/seq_hit_model.sv
// seq_hit_model: 3-bit history of the bits sent in the current frame and
// the overlapping 111/101 hit flag for the bit currently presented.
// Ports:
//   clk       in  clock, rising edge
//   rst       in  asynchronous active-low reset
//   clr       in  clear the history (start of a new frame)
//   bit_valid in  bit_in carries a frame bit this cycle
//   bit_in    in  current frame bit (bit k)
//   hit       out bit k closes a 111 or 101 window (combinational)
module seq_hit_model (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_valid,
  input  logic bit_in,
  output logic hit
);

  // hist[1] is bit k-2, hist[0] is bit k-1. Clearing to zero means the
  // first two bits of a frame can never produce a hit.
  logic [1:0] hist;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= 2'b00;
    end else if (clr) begin
      hist <= 2'b00;
    end else if (bit_valid) begin
      hist <= {hist[0], bit_in};
    end
  end

  // 111 and 101 both reduce to "bit k and bit k-2 are set".
  assign hit = bit_valid & bit_in & hist[1];

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter feeding a 111/101 overlapping
// detector. A frame is accepted over valid/ready, shifted out MSB-first,
// followed by a zero gap; the expected detector hit count is reported.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   load_valid in   frame offered
//   load_ready out  frame can be accepted (state is IDLE)
//   load_data  in   frame bits, bit len-1 sent first
//   load_len   in   bits to send; 0 or >WIDTH means WIDTH
//   o          out  serial bit, 0 whenever o_valid is low
//   o_valid    out  a frame bit is on o
//   done       out  one-cycle pulse in the first gap cycle
//   exp_hits   out  expected detector hits for the last completed frame
//   dbg_state  out  current FSM state (tx_state_t encoding)
//
// Handshake: a transfer happens on a rising edge where load_valid and
// load_ready are both high; load_data/load_len are sampled only then,
// and load_valid may be held high to queue the next frame.
module seq_pattern_tx
  import seq_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = $clog2(WIDTH + 1),
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CNT_W-1:0] load_len,
  output logic             o,
  output logic             o_valid,
  output logic             done,
  output logic [CNT_W-1:0] exp_hits,
  output logic [1:0]       dbg_state
);

  localparam int               GAP_EFF  = eff_gap(GAP_CYCLES);
  localparam int               GAP_W    = $clog2(GAP_EFF);
  localparam logic [CNT_W-1:0] WIDTH_C  = CNT_W'(WIDTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_EFF - 1);

  tx_state_t        state_q;
  logic [WIDTH-1:0] shreg;     // remaining bits, next bit at the MSB
  logic [CNT_W-1:0] bit_cnt;   // bits still to send after the one on o
  logic [GAP_W-1:0] gap_cnt;   // gap cycles left after the current one
  logic [CNT_W-1:0] hit_cnt;   // hits counted for bits already sent

  logic [CNT_W-1:0] len_eff;
  logic [CNT_W-1:0] shamt;
  logic [WIDTH-1:0] aligned;
  logic [CNT_W-1:0] hit_sum;
  logic             accept;
  logic             hit;

  assign load_ready = (state_q == TX_IDLE);
  assign accept     = load_valid & load_ready;
  assign dbg_state  = state_q;

  // Left-align the frame so the first bit always sits at the MSB and the
  // shifter never needs a variable bit index.
  always_comb begin
    len_eff = load_len;
    if (load_len == '0 || load_len > WIDTH_C) begin
      len_eff = WIDTH_C;
    end
    shamt   = WIDTH_C - len_eff;
    aligned = load_data << shamt;
  end

  // The bit on o during a SHIFT cycle is judged against its history in
  // that same cycle, so hit_sum already includes the current bit.
  assign hit_sum = hit_cnt + CNT_W'(hit);

  seq_hit_model u_hit (
    .clk       (clk),
    .rst       (rst),
    .clr       (accept),
    .bit_valid (o_valid),
    .bit_in    (o),
    .hit       (hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= TX_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      hit_cnt  <= '0;
      o        <= 1'b0;
      o_valid  <= 1'b0;
      done     <= 1'b0;
      exp_hits <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        TX_IDLE: begin
          if (load_valid) begin
            o       <= aligned[WIDTH-1];
            o_valid <= 1'b1;
            shreg   <= aligned << 1;
            bit_cnt <= len_eff - CNT_W'(1);
            hit_cnt <= '0;
            state_q <= TX_SHIFT;
          end
        end
        TX_SHIFT: begin
          hit_cnt <= hit_sum;
          if (bit_cnt == '0) begin
            // Last bit is on o now; done lines up with the detector's
            // registered output for that bit.
            o        <= 1'b0;
            o_valid  <= 1'b0;
            done     <= 1'b1;
            exp_hits <= hit_sum;
            gap_cnt  <= GAP_LAST;
            state_q  <= TX_GAP;
          end else begin
            o       <= shreg[WIDTH-1];
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - CNT_W'(1);
          end
        end
        TX_GAP: begin
          if (gap_cnt == '0) begin
            state_q <= TX_IDLE;
          end else begin
            gap_cnt <= gap_cnt - GAP_W'(1);
          end
        end
        default: begin
          state_q <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// tb_seq_pattern_tx: directed and random frames for seq_pattern_tx with a
// behavioural 111/101 detector on 'o' and an expected-hits queue.
module tb_seq_pattern_tx;
  import seq_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] load_data;
  logic [3:0] load_len;
  logic       o;
  logic       o_valid;
  logic       done;
  logic [3:0] exp_hits;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(8), .CNT_W(4), .GAP_CYCLES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_len   (load_len),
    .o          (o),
    .o_valid    (o_valid),
    .done       (done),
    .exp_hits   (exp_hits),
    .dbg_state  (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference hit count straight from the frame contents.
  function automatic logic [3:0] ref_hits(input logic [7:0] d, input logic [3:0] l);
    int n;
    int h;
    n = (l == 4'd0 || l > 4'd8) ? 8 : int'(l);
    h = 0;
    for (int k = 2; k < n; k++) begin
      if (d[n-1-k] && d[n-1-(k-2)]) h++;
    end
    return 4'(h);
  endfunction

  // ---------------- detector model + scoreboard ----------------
  logic [1:0] det_h;
  logic       det_y;
  int         y_cnt = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      det_h <= 2'b00;
      det_y <= 1'b0;
    end else begin
      det_y <= ({det_h, o} == 3'b111) || ({det_h, o} == 3'b101);
      det_h <= {det_h[0], o};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (det_y) y_cnt++;
      if (!o_valid) chk("o_zero_idle", {31'b0, o}, 32'd0);
      if (done) begin
        chk("sb_nonempty", (exp_q.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (exp_q.size() > 0) chk("sb_exp_hits", {28'b0, exp_hits}, {28'b0, exp_q.pop_front()});
        chk("det_y_count", {28'b0, exp_hits}, 32'(y_cnt));
        y_cnt = 0;
      end
      if (load_valid && load_ready) exp_q.push_back(ref_hits(load_data, load_len));
    end else begin
      exp_q.delete();
      y_cnt = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_accept(input logic [7:0] d, input logic [3:0] l);
    int n;
    @(posedge clk);
    #1;
    load_data  = d;
    load_len   = l;
    load_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!load_ready && n < 32);
    chk("accept_ready", {31'b0, load_ready}, 32'd1);
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = 8'($urandom_range(0, 255));
    load_len   = 4'($urandom_range(0, 15));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 64);
    chk("done_seen", {31'b0, done}, 32'd1);
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!load_ready && n < 16) begin
      @(negedge clk);
      n++;
    end
    chk("ready_return", {31'b0, load_ready}, 32'd1);
  endtask

  // Called in cycle A+1; checks every bit, the done cycle and the gap.
  task automatic check_frame(input logic [7:0] d, input int n, input logic [3:0] eh, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk({tag, "_o"}, {31'b0, o}, {31'b0, d[n-1-k]});
      chk({tag, "_ov"}, {31'b0, o_valid}, 32'd1);
      chk({tag, "_no_done"}, {31'b0, done}, 32'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, {31'b0, done}, 32'd1);
    chk({tag, "_hits"}, {28'b0, exp_hits}, {28'b0, eh});
    chk({tag, "_gap_ov"}, {31'b0, o_valid}, 32'd0);
    chk({tag, "_gap_ready"}, {31'b0, load_ready}, 32'd0);
    chk({tag, "_state_gap"}, {30'b0, dbg_state}, {30'b0, TX_GAP});
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, "_gap2_o"}, {31'b0, o}, 32'd0);
    chk({tag, "_gap2_ready"}, {31'b0, load_ready}, 32'd0);
    @(negedge clk);
    chk({tag, "_ready_back"}, {31'b0, load_ready}, 32'd1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst        = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_len   = 4'd0;

    @(negedge clk);
    chk("rst_o", {31'b0, o}, 32'd0);
    chk("rst_ov", {31'b0, o_valid}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_hits", {28'b0, exp_hits}, 32'd0);
    chk("rst_ready", {31'b0, load_ready}, 32'd1);
    chk("rst_state", {30'b0, dbg_state}, {30'b0, TX_IDLE});
    @(posedge clk);
    #1 rst = 1'b1;

    // 1110_1101, len 8 -> 3 hits
    drive_accept(8'b1110_1101, 4'd8);
    check_frame(8'b1110_1101, 8, 4'd3, "t1");

    // all ones, len 0 means full width -> 6 hits
    drive_accept(8'hFF, 4'd0);
    check_frame(8'hFF, 8, 4'd6, "t2");

    // short frame -> no hits
    drive_accept(8'b0000_0011, 4'd2);
    check_frame(8'b0000_0011, 2, 4'd0, "t3");

    // valid held high with a second word queued behind the first
    @(posedge clk);
    #1;
    load_data  = 8'b1010_1010;
    load_len   = 4'd8;
    load_valid = 1'b1;
    @(negedge clk);
    chk("t4_ready_a", {31'b0, load_ready}, 32'd1);
    @(posedge clk);  // edge A
    #1;
    load_data = 8'b1011_0111;
    load_len  = 4'd8;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      chk("t4_busy", {31'b0, load_ready}, 32'd0);
      if (c == 9) begin
        chk("t4_done", {31'b0, done}, 32'd1);
        chk("t4_hits", {28'b0, exp_hits}, 32'd3);
      end
    end
    @(negedge clk);  // A+11
    chk("t4_second_accept", {31'b0, load_ready}, 32'd1);
    @(posedge clk);
    #1 load_valid = 1'b0;
    @(negedge clk);  // A+12
    chk("t4_second_ov", {31'b0, o_valid}, 32'd1);
    chk("t4_second_o", {31'b0, o}, 32'd1);
    wait_done();
    chk("t4_second_hits", {28'b0, exp_hits}, 32'd3);
    wait_ready();

    // reset during the 4th bit aborts the frame
    drive_accept(8'hFF, 4'd8);
    repeat (3) @(posedge clk);  // start of A+4
    #1;
    chk("t5_mid_ov", {31'b0, o_valid}, 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("t5_rst_o", {31'b0, o}, 32'd0);
    chk("t5_rst_ov", {31'b0, o_valid}, 32'd0);
    chk("t5_rst_hits", {28'b0, exp_hits}, 32'd0);
    chk("t5_rst_ready", {31'b0, load_ready}, 32'd1);
    repeat (4) begin
      @(negedge clk);
      chk("t5_no_done", {31'b0, done}, 32'd0);
      chk("t5_hold_hits", {28'b0, exp_hits}, 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    drive_accept(8'b0000_0101, 4'd3);
    wait_done();
    chk("t5_recover_hits", {28'b0, exp_hits}, 32'd1);
    wait_ready();

    // random frames with random idle gaps, lengths include 0 and >8
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      drive_accept(8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)));
      wait_done();
      wait_ready();
    end

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
